// File: rtl/const_op_pkg.sv
// Shared types and constant table for the constant add/subtract datapath.
// Constants are zero-extended to the requested word width.
package const_op_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned CONST_MAX_WIDTH = 64;
  localparam int unsigned CONST_BITS      = 3;

  // Index 0 is the rightmost entry: sel 0->1, 1->3, 2->5, 3->7
  localparam logic [3:0][CONST_BITS-1:0] CONST_TABLE = {3'd7, 3'd5, 3'd3, 3'd1};

  function automatic logic [CONST_MAX_WIDTH-1:0] const_value(
    input logic [1:0]  sel,
    input int unsigned width
  );
    logic [CONST_MAX_WIDTH-1:0] value;
    value = CONST_MAX_WIDTH'(CONST_TABLE[sel]);
    if (width < CONST_MAX_WIDTH) begin
      value = value & ((CONST_MAX_WIDTH'(1) << width) - CONST_MAX_WIDTH'(1));
    end
    return value;
  endfunction

endpackage

// File: rtl/full_adder_1_bit.sv
// Single-bit full adder cell, shared with the ripple adder elsewhere in the datapath.
module full_adder_1_bit (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  always_comb begin
    sum   = a ^ b ^ c_in;
    c_out = (a & b) | (a & c_in) | (b & c_in);
  end

endmodule

// File: rtl/serial_const_inverse.sv
// Bit-serial inverse of the constant add/subtract stage: recovers the operand
// from a result word, LSB first through one full adder per cycle.
module serial_const_inverse
  import const_op_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [1:0]       in_select,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           nextState;
  logic [WIDTH-1:0] aSr;
  logic [WIDTH-1:0] bSr;
  logic [WIDTH-1:0] resSr;
  logic [WIDTH-1:0] kVal;
  logic             carry;
  logic [CNT_W-1:0] bitCount;
  logic             accept;
  logic             busyStep;
  logic             lastBit;
  logic             faSum;
  logic             faCout;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (accept)    nextState = BUSY;
      BUSY:    if (lastBit)   nextState = DONE;
      DONE:    if (out_ready) nextState = IDLE;
      default:                nextState = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    kVal     = WIDTH'(const_value(in_select, WIDTH));
    accept   = in_valid && in_ready;
    busyStep = (state == BUSY);
    lastBit  = busyStep && (bitCount == CNT_W'(WIDTH - 1));
  end

  full_adder_1_bit fa (
    .a     (aSr[0]),
    .b     (bSr[0]),
    .c_in  (carry),
    .sum   (faSum),
    .c_out (faCout)
  );

  // Undoing an add is a two's-complement subtract: invert K and inject carry 1
  always_ff @(posedge clk) begin
    if (reset) begin
      aSr       <= '0;
      bSr       <= '0;
      resSr     <= '0;
      carry     <= 1'b0;
      bitCount  <= '0;
      out_data  <= '0;
      out_carry <= 1'b0;
    end else if (accept) begin
      aSr      <= in_result;
      bSr      <= in_op ? kVal : ~kVal;
      carry    <= ~in_op;
      bitCount <= '0;
    end else if (busyStep) begin
      aSr      <= {1'b0, aSr[WIDTH-1:1]};
      bSr      <= {1'b0, bSr[WIDTH-1:1]};
      resSr    <= {faSum, resSr[WIDTH-1:1]};
      carry    <= faCout;
      bitCount <= bitCount + CNT_W'(1);
      if (lastBit) begin
        out_data  <= {faSum, resSr[WIDTH-1:1]};
        out_carry <= faCout;
      end
    end
  end

endmodule

// File: tb/tb_serial_const_inverse.sv
// Scoreboard bench for serial_const_inverse: accepted words push an arithmetic
// reference result, an output monitor pops and compares on each handshake.
module tb_serial_const_inverse;

  localparam int unsigned WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             carry;
    int unsigned      acceptCycle;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [1:0]       in_select;
  logic             in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;

  int unsigned cycle = 0;
  int          checks = 0;
  int          errors = 0;
  int          readyMode = 1;
  bit          seenValid = 1'b0;
  exp_t        expQ[$];
  int unsigned acceptLog[$];

  serial_const_inverse #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_select (in_select),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Reference: undo result = operand +/- K with plain modular arithmetic
  function automatic exp_t model(input logic [WIDTH-1:0] r, input logic [1:0] sel, input logic op);
    exp_t e;
    int   k;
    int   rv;
    int   sum;
    int   modulus;
    modulus = 1 << WIDTH;
    k  = 2 * int'(sel) + 1;
    rv = int'(r);
    if (op) begin
      sum     = rv + k;
      e.carry = (sum >= modulus);
      e.data  = WIDTH'(sum % modulus);
    end else begin
      sum     = rv - k;
      e.carry = (rv >= k);
      if (sum < 0) sum += modulus;
      e.data  = WIDTH'(sum);
    end
    e.acceptCycle = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cycle);
  endtask

  // Sole driver of out_ready: 0 = held low, 1 = held high, 2 = random per cycle
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Accept monitor: the word is taken on the coming rising edge
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && in_valid === 1'b1 && in_ready === 1'b1) begin
      e = model(in_result, in_select, in_op);
      e.acceptCycle = cycle;
      expQ.push_back(e);
      acceptLog.push_back(cycle);
    end
  end

  // Output monitor: latency on first sight of out_valid, data on handshake
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        failNow("unexpected_output");
      end else begin
        if (!seenValid) begin
          check("latency", 32'(cycle - expQ[0].acceptCycle), 32'(WIDTH + 1));
          seenValid = 1'b1;
        end
        if (out_ready === 1'b1) begin
          check("out_data", 32'(out_data), 32'(expQ[0].data));
          check("out_carry", 32'(out_carry), 32'(expQ[0].carry));
          void'(expQ.pop_front());
          seenValid = 1'b0;
        end
      end
    end
  end

  task automatic sendWord(input logic [WIDTH-1:0] r, input logic [1:0] sel, input logic op,
                          input bit keepValid);
    bit taken;
    taken = 1'b0;
    @(posedge clk);
    #1;
    in_result = r;
    in_select = sel;
    in_op     = op;
    in_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        taken = 1'b1;
        break;
      end
    end
    if (!taken) failNow("accept_timeout");
    @(posedge clk);
    #1;
    if (!keepValid) in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    bit drained;
    drained = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (expQ.size() == 0 && in_ready === 1'b1) begin
        drained = 1'b1;
        break;
      end
    end
    if (!drained) failNow("drain_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bit   seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_result = '0;
    in_select = '0;
    in_op     = 1'b0;
    readyMode = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_carry", 32'(out_carry), 32'd0);

    // Directed cases: plain subtract, wrap with borrow, overflow wrap
    sendWord(8'h04, 2'd1, 1'b0, 1'b0);
    waitDrain();
    sendWord(8'h00, 2'd0, 1'b0, 1'b0);
    waitDrain();
    sendWord(8'hFE, 2'd3, 1'b1, 1'b0);
    waitDrain();

    // Back-pressure: result must stay put while out_ready is low
    readyMode = 0;
    sendWord(8'h37, 2'd2, 1'b0, 1'b0);
    e = model(8'h37, 2'd2, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) failNow("bp_valid_timeout");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_data", 32'(out_data), 32'(e.data));
      check("bp_out_carry", 32'(out_carry), 32'(e.carry));
    end
    readyMode = 1;
    waitDrain();
    check("bp_idle_after", 32'(in_ready), 32'd1);
    check("bp_data_held", 32'(out_data), 32'(e.data));

    // Reset on the 4th busy cycle aborts the word
    sendWord(8'h5A, 2'd1, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    expQ.delete();
    seenValid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_data", 32'(out_data), 32'd0);
    check("abort_out_carry", 32'(out_carry), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_output", 32'(out_valid), 32'd0);
    end

    // Randomised words with random back-pressure and idle gaps
    readyMode = 2;
    for (int n = 0; n < 30; n++) begin
      sendWord(WIDTH'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    readyMode = 1;
    waitDrain();

    // Streaming: in_valid held high across every sel/op pair
    acceptLog.delete();
    for (int p = 0; p < 8; p++) begin
      sendWord(WIDTH'($urandom), 2'(p % 4), 1'(p / 4), 1'b1);
    end
    in_valid = 1'b0;
    waitDrain();
    check("stream_accepts", 32'(acceptLog.size()), 32'd8);
    for (int i = 1; i < acceptLog.size(); i++) begin
      check("stream_spacing", 32'(acceptLog[i] - acceptLog[i-1]), 32'(WIDTH + 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
